// File: rtl/arch_defs_pkg.sv
// Shared architecture definitions: condition codes, PC action encoding and the
// default address width used by the program-counter datapath.
package arch_defs_pkg;

    localparam int ADDR_WIDTH_DEFAULT = 8;

    typedef enum logic [2:0] {
        COND_ALWAYS = 3'b000,
        COND_Z      = 3'b001,
        COND_NZ     = 3'b010,
        COND_C      = 3'b011,
        COND_NC     = 3'b100,
        COND_N      = 3'b101,
        COND_NN     = 3'b110,
        COND_NEVER  = 3'b111
    } cond_e;

    typedef enum logic [2:0] {
        ACT_HOLD,
        ACT_INC,
        ACT_LOAD,
        ACT_CALL,
        ACT_RET
    } pc_act_e;

endpackage

// File: rtl/return_stack.sv
// LIFO of return addresses; push is ignored when full, pop is ignored when empty.
module return_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         data,
    output logic [WIDTH-1:0]         top,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   depth
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   count;

    assign full  = (count == (PTR_W + 1)'(DEPTH));
    assign empty = (count == '0);
    assign depth = count;
    assign top   = mem[PTR_W'(count - 1'b1)];

    // NOTE: the storage array has no reset; only the occupancy count defines which entries are valid.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[count[PTR_W-1:0]] <= data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (push && !full) begin
            count <= count + 1'b1;
        end else if (pop && !empty) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/pc_branch_unit.sv
// Program counter with condition evaluation, jumps and (with BRANCH_STACK_EN
// defined) a return-address stack for conditional call/return.
module pc_branch_unit
    import arch_defs_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = ADDR_WIDTH_DEFAULT,
    parameter int                    STACK_DEPTH  = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           pc_inc_i,
    input  logic                           branch_en_i,
    input  logic                           call_i,
    input  logic                           ret_i,
    input  logic [2:0]                     cond_i,
    input  logic [ADDR_WIDTH-1:0]          target_i,
    input  logic                           flag_zero_i,
    input  logic                           flag_carry_i,
    input  logic                           flag_negative_i,
    output logic [ADDR_WIDTH-1:0]          pc_o,
    output logic                           branch_taken_o,
    output logic [$clog2(STACK_DEPTH):0]   depth_o,
    output logic                           stack_overflow_o,
    output logic                           stack_underflow_o
);

    function automatic logic cond_eval(input cond_e cond, input logic z, input logic c,
                                       input logic n);
        case (cond)
            COND_ALWAYS: return 1'b1;
            COND_Z:      return z;
            COND_NZ:     return !z;
            COND_C:      return c;
            COND_NC:     return !c;
            COND_N:      return n;
            COND_NN:     return !n;
            default:     return 1'b0;
        endcase
    endfunction

    pc_act_e               act;
    logic                  cond_true;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] stack_top;
    logic                  taken_q;

    assign cond_true = cond_eval(cond_e'(cond_i), flag_zero_i, flag_carry_i, flag_negative_i);

`ifdef BRANCH_STACK_EN
    logic stack_full, stack_empty;
    logic ovf_set, unf_set, ovf_q, unf_q;

    return_stack #(
        .WIDTH (ADDR_WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_return_stack (
        .clk   (clk),
        .reset (reset),
        .push  (act == ACT_CALL),
        .pop   (act == ACT_RET),
        .data  (pc_q),
        .top   (stack_top),
        .full  (stack_full),
        .empty (stack_empty),
        .depth (depth_o)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        act     = ACT_HOLD;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (ret_i) begin
            if (stack_empty) unf_set = 1'b1;
            else             act     = ACT_RET;
        end else if (call_i) begin
            // A failed-condition call degrades to inc/hold, never to a plain branch.
            if (cond_true) begin
                if (stack_full) ovf_set = 1'b1;
                else            act     = ACT_CALL;
            end else if (pc_inc_i) begin
                act = ACT_INC;
            end
        end else if (branch_en_i && cond_true) begin
            act = ACT_LOAD;
        end else if (pc_inc_i) begin
            act = ACT_INC;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (ovf_set) ovf_q <= 1'b1;
            if (unf_set) unf_q <= 1'b1;
        end
    end

    assign stack_overflow_o  = ovf_q;
    assign stack_underflow_o = unf_q;
`else
    // Without a stack, call is just another jump strobe and ret has no effect.
    logic unused_ret;
    assign unused_ret = ret_i;

    always_comb begin
        act = ACT_HOLD;
        if ((call_i || branch_en_i) && cond_true) act = ACT_LOAD;
        else if (pc_inc_i)                        act = ACT_INC;
    end

    assign stack_top         = '0;
    assign depth_o           = '0;
    assign stack_overflow_o  = 1'b0;
    assign stack_underflow_o = 1'b0;
`endif

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q    <= RESET_VECTOR;
            taken_q <= 1'b0;
        end else begin
            case (act)
                ACT_INC:            pc_q <= pc_q + ADDR_WIDTH'(1);
                ACT_LOAD, ACT_CALL: pc_q <= target_i;
                ACT_RET:            pc_q <= stack_top;
                default:            pc_q <= pc_q;
            endcase
            taken_q <= (act == ACT_LOAD) || (act == ACT_CALL) || (act == ACT_RET);
        end
    end

    assign pc_o           = pc_q;
    assign branch_taken_o = taken_q;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Self-checking bench for pc_branch_unit: reference model plus directed vectors
// with literal expectations; stack scenarios run when BRANCH_STACK_EN is defined.
module tb_pc_branch_unit;
    import arch_defs_pkg::*;

    localparam logic [7:0] RV = 8'h10;

    logic       clk, reset;
    logic       pc_inc_i, branch_en_i, call_i, ret_i;
    logic [2:0] cond_i;
    logic [7:0] target_i;
    logic       flag_zero_i, flag_carry_i, flag_negative_i;
    logic [7:0] pc_o;
    logic       branch_taken_o;
    logic [2:0] depth_o;
    logic       stack_overflow_o, stack_underflow_o;

    logic        inc12, br12;
    logic [11:0] tgt12, pc12;
    logic        tie0;
    logic        taken12, ovf12, unf12;
    logic [2:0]  depth12;

    int checks = 0;
    int errors = 0;

    pc_branch_unit #(.ADDR_WIDTH(8), .STACK_DEPTH(4), .RESET_VECTOR(RV)) dut (
        .clk(clk), .reset(reset), .pc_inc_i(pc_inc_i), .branch_en_i(branch_en_i),
        .call_i(call_i), .ret_i(ret_i), .cond_i(cond_i), .target_i(target_i),
        .flag_zero_i(flag_zero_i), .flag_carry_i(flag_carry_i),
        .flag_negative_i(flag_negative_i), .pc_o(pc_o), .branch_taken_o(branch_taken_o),
        .depth_o(depth_o), .stack_overflow_o(stack_overflow_o),
        .stack_underflow_o(stack_underflow_o)
    );

    pc_branch_unit #(.ADDR_WIDTH(12), .STACK_DEPTH(4), .RESET_VECTOR(12'h000)) dut12 (
        .clk(clk), .reset(reset), .pc_inc_i(inc12), .branch_en_i(br12),
        .call_i(tie0), .ret_i(tie0), .cond_i(3'b000), .target_i(tgt12),
        .flag_zero_i(tie0), .flag_carry_i(tie0), .flag_negative_i(tie0),
        .pc_o(pc12), .branch_taken_o(taken12), .depth_o(depth12),
        .stack_overflow_o(ovf12), .stack_underflow_o(unf12)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] m_pc;
    logic       m_taken, m_ovf, m_unf;
    int         m_depth;
    logic [7:0] m_mem [4];

    function automatic bit cond_holds(input logic [2:0] c, input logic z, input logic cy,
                                      input logic n);
        case (c)
            3'd0:    return 1'b1;
            3'd1:    return z;
            3'd2:    return !z;
            3'd3:    return cy;
            3'd4:    return !cy;
            3'd5:    return n;
            3'd6:    return !n;
            default: return 1'b0;
        endcase
    endfunction

    always @(posedge clk or negedge reset) begin : model
        bit ok;
        if (!reset) begin
            m_pc    <= RV;
            m_taken <= 1'b0;
            m_depth <= 0;
            m_ovf   <= 1'b0;
            m_unf   <= 1'b0;
        end else begin
            ok = cond_holds(cond_i, flag_zero_i, flag_carry_i, flag_negative_i);
            m_taken <= 1'b0;
`ifdef BRANCH_STACK_EN
            if (ret_i) begin
                if (m_depth == 0) m_unf <= 1'b1;
                else begin
                    m_pc    <= m_mem[m_depth-1];
                    m_depth <= m_depth - 1;
                    m_taken <= 1'b1;
                end
            end else if (call_i) begin
                if (ok) begin
                    if (m_depth == 4) m_ovf <= 1'b1;
                    else begin
                        m_mem[m_depth] <= m_pc;
                        m_depth        <= m_depth + 1;
                        m_pc           <= target_i;
                        m_taken        <= 1'b1;
                    end
                end else if (pc_inc_i) m_pc <= m_pc + 8'd1;
            end else if (branch_en_i && ok) begin
                m_pc    <= target_i;
                m_taken <= 1'b1;
            end else if (pc_inc_i) m_pc <= m_pc + 8'd1;
`else
            if ((call_i || branch_en_i) && ok) begin
                m_pc    <= target_i;
                m_taken <= 1'b1;
            end else if (pc_inc_i) m_pc <= m_pc + 8'd1;
`endif
        end
    end

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            check("model_pc", pc_o, m_pc);
            check("model_taken", branch_taken_o, m_taken);
            check("model_depth", depth_o, m_depth[2:0]);
            check("model_ovf", stack_overflow_o, m_ovf);
            check("model_unf", stack_underflow_o, m_unf);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic inc, input logic br, input logic cl, input logic rt,
                        input logic [2:0] c, input logic [7:0] t);
        pc_inc_i    = inc;
        branch_en_i = br;
        call_i      = cl;
        ret_i       = rt;
        cond_i      = c;
        target_i    = t;
        @(negedge clk);
        pc_inc_i    = 1'b0;
        branch_en_i = 1'b0;
        call_i      = 1'b0;
        ret_i       = 1'b0;
    endtask

    task automatic set_flags(input logic [2:0] f);
        flag_zero_i     = f[0];
        flag_carry_i    = f[1];
        flag_negative_i = f[2];
    endtask

    logic [63:0] taken_mask;

    initial begin
        reset = 1'b0;
        pc_inc_i = 0; branch_en_i = 0; call_i = 0; ret_i = 0;
        cond_i = 3'd0; target_i = 8'h00;
        set_flags(3'b000);
        inc12 = 0; br12 = 0; tgt12 = 12'h000; tie0 = 1'b0;
        taken_mask = 64'h00_0F_F0_33_CC_55_AA_FF;

        repeat (2) @(negedge clk);
        check("reset_pc", pc_o, 8'h10);
        check("reset_taken", branch_taken_o, 1'b0);
        check("reset_depth", depth_o, 3'd0);
        reset = 1'b1;
        @(negedge clk);
        check("hold_pc", pc_o, 8'h10);

        step(1, 0, 0, 0, 3'd0, 8'h00);
        check("inc1", pc_o, 8'h11);
        step(1, 0, 0, 0, 3'd0, 8'h00);
        check("inc2", pc_o, 8'h12);
        step(1, 0, 0, 0, 3'd0, 8'h00);
        check("inc3", pc_o, 8'h13);
        check("inc_no_pulse", branch_taken_o, 1'b0);

        set_flags(3'b001);
        step(0, 1, 0, 0, COND_Z, 8'h05);
        check("bz_taken_pc", pc_o, 8'h05);
        check("bz_taken_pulse", branch_taken_o, 1'b1);
        step(0, 0, 0, 0, 3'd0, 8'h00);
        check("bz_pulse_ends", branch_taken_o, 1'b0);
        set_flags(3'b000);
        step(1, 1, 0, 0, COND_Z, 8'h05);
        check("bz_not_taken_inc", pc_o, 8'h06);
        check("bz_not_taken_pulse", branch_taken_o, 1'b0);
        step(0, 1, 0, 0, COND_Z, 8'h77);
        check("bz_not_taken_hold", pc_o, 8'h06);

        for (int c = 0; c < 8; c++) begin
            for (int f = 0; f < 8; f++) begin
                set_flags(f[2:0]);
                step(0, 1, 0, 0, c[2:0], 8'h40 + 8'(c * 8 + f));
                check($sformatf("sweep_c%0d_f%0d", c, f), branch_taken_o, taken_mask[c*8+f]);
            end
        end
        set_flags(3'b000);

        step(0, 1, 0, 0, COND_ALWAYS, 8'hFF);
        step(1, 0, 0, 0, 3'd0, 8'h00);
        check("wrap8", pc_o, 8'h00);

        br12 = 1'b1; tgt12 = 12'hFFF;
        @(negedge clk);
        br12 = 1'b0; inc12 = 1'b1;
        check("load12", pc12, 12'hFFF);
        @(negedge clk);
        inc12 = 1'b0;
        check("wrap12", pc12, 12'h000);

`ifdef BRANCH_STACK_EN
        for (int k = 0; k < 4; k++) begin
            step(0, 1, 0, 0, COND_ALWAYS, 8'h20 + 8'(k * 16));
            step(0, 0, 1, 0, COND_ALWAYS, 8'h80);
            check("call_pc", pc_o, 8'h80);
        end
        check("depth_full", depth_o, 3'd4);
        step(0, 0, 1, 0, COND_ALWAYS, 8'h99);
        check("ovf_pc_hold", pc_o, 8'h80);
        check("ovf_flag", stack_overflow_o, 1'b1);
        check("ovf_depth", depth_o, 3'd4);
        check("ovf_no_pulse", branch_taken_o, 1'b0);
        step(0, 0, 0, 1, 3'd0, 8'h00);
        check("ret1", pc_o, 8'h50);
        step(0, 0, 0, 1, 3'd0, 8'h00);
        check("ret2", pc_o, 8'h40);
        step(0, 0, 0, 1, 3'd0, 8'h00);
        check("ret3", pc_o, 8'h30);
        step(0, 0, 0, 1, 3'd0, 8'h00);
        check("ret4", pc_o, 8'h20);
        step(1, 0, 0, 1, 3'd0, 8'h00);
        check("unf_pc_hold", pc_o, 8'h20);
        check("unf_flag", stack_underflow_o, 1'b1);
        check("ovf_sticky", stack_overflow_o, 1'b1);

        step(1, 0, 1, 0, COND_NEVER, 8'h99);
        check("call_false_inc", pc_o, 8'h21);
        check("call_false_depth", depth_o, 3'd0);

        step(0, 1, 0, 0, COND_ALWAYS, 8'h20);
        step(0, 0, 1, 0, COND_ALWAYS, 8'h80);
        step(0, 1, 0, 0, COND_ALWAYS, 8'h30);
        step(0, 0, 1, 0, COND_ALWAYS, 8'h80);
        check("depth_two", depth_o, 3'd2);
        step(0, 0, 1, 1, COND_ALWAYS, 8'h99);
        check("callret_pc", pc_o, 8'h30);
        check("callret_depth", depth_o, 3'd1);

        step(0, 1, 0, 0, COND_ALWAYS, 8'h77);
        step(0, 0, 1, 0, COND_ALWAYS, 8'h90);
        step(0, 0, 0, 1, 3'd0, 8'h00);
        check("call_then_ret", pc_o, 8'h77);
        check("call_then_ret_depth", depth_o, 3'd1);
`else
        set_flags(3'b001);
        step(0, 0, 1, 0, COND_Z, 8'h33);
        check("call_as_branch", pc_o, 8'h33);
        check("call_as_branch_pulse", branch_taken_o, 1'b1);
        check("nostack_depth", depth_o, 3'd0);
        set_flags(3'b000);
        step(1, 0, 0, 1, 3'd0, 8'h00);
        check("ret_ignored_inc", pc_o, 8'h34);
        step(0, 0, 0, 1, 3'd0, 8'h00);
        check("ret_ignored_hold", pc_o, 8'h34);
        check("nostack_unf", stack_underflow_o, 1'b0);
`endif

        step(1, 0, 0, 0, 3'd0, 8'h00);
        step(0, 1, 0, 0, COND_ALWAYS, 8'hC4);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_pc", pc_o, 8'h10);
        check("async_reset_depth", depth_o, 3'd0);
        check("async_reset_taken", branch_taken_o, 1'b0);
        check("async_reset_ovf", stack_overflow_o, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        step(1, 0, 0, 0, 3'd0, 8'h00);
        check("post_reset_inc", pc_o, 8'h11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_branch_unit.md
# pc_branch_unit

Parametrised program counter with integrated condition evaluation and an optional return-address stack. It generalises the fixed 8-bit PC and hard-wired JZ/JC/JN load path into one block. It supports eight condition codes, conditional call/return, and arbitrary address width. It sits in the CPU between the control unit (microstep strobes) and the ALU flag register, and drives the memory address path.

## Interface
- `ADDR_WIDTH`, 8, PC and target width
- `STACK_DEPTH`, 4, return-stack entries (≥2, power of two)
- `RESET_VECTOR`, 0, PC value after reset
- `clk`  in  1  system clock, rising-edge
- `reset`  in  1  asynchronous, active-low reset
- `pc_inc_i`  in  1  increment PC this cycle
- `branch_en_i`  in  1  jump microstep strobe
- `call_i`  in  1  call microstep strobe
- `ret_i`  in  1  return microstep strobe
- `cond_i`  in  3  condition code (`cond_e`)
- `target_i`  in  ADDR_WIDTH  branch/call target
- `flag_zero_i`, `flag_carry_i`, `flag_negative_i`  in  1 each  registered ALU flags
- `pc_o`  out  ADDR_WIDTH  current PC
- `branch_taken_o`  out  1  one-cycle pulse: PC was loaded by branch/call/ret on the previous edge
- `depth_o`  out  $clog2(STACK_DEPTH)+1  current stack occupancy
- `stack_overflow_o`  out  1  sticky error flag
- `stack_underflow_o`  out  1  sticky error flag

## Operation
- Conditions (`cond_e`): 000 ALWAYS, 001 Z, 010 NZ, 011 C, 100 NC, 101 N, 110 NN, 111 NEVER. `cond_true` is evaluated combinationally from the flag inputs in the same cycle as the strobe.
- Per-cycle action is chosen by fixed priority: ret > call > branch > inc > hold.
- ret: pop the top of stack into the PC. `cond_i` is ignored for ret.
- call, with `cond_true`: push the current `pc_o` and load `target_i`. With the condition false, call behaves as inc if `pc_inc_i` is high, otherwise hold.
- branch, with `cond_true`: load `target_i`. With the condition false, it falls through to inc/hold. A not-taken branch never modifies the PC on its own.
- inc: `pc_o + 1` modulo 2^ADDR_WIDTH. All-ones wraps to 0 with no flag.
- Overflow: call when `depth_o == STACK_DEPTH` performs no push and no jump, and the PC holds. `stack_overflow_o` sets.
- Underflow: ret when `depth_o == 0` leaves the PC unchanged. `stack_underflow_o` sets.
- Sticky flags clear only on reset.
- `branch_taken_o` is asserted only for a successful load (taken branch, successful call, successful ret).

## Timing
- Reset (async assert, sync release): `pc_o = RESET_VECTOR`, `depth_o = 0`, stack pointer 0, `branch_taken_o = 0`, both error flags 0. Stack RAM contents are don't-care.
- Latency: the PC update is visible one edge after the strobe. `branch_taken_o` is high for the cycle following that edge.
- Flags are sampled in the strobe cycle. A flag change in that same cycle (ALU writeback) is seen, so the producer must register its flags.
- Call followed immediately by ret on the next cycle returns the pushed address. Back-to-back operations need no bubble.
- Simultaneous call+ret: ret wins. No push occurs, and depth decreases by 1.
- Reset asserted mid-sequence clears the PC and stack immediately, regardless of the clock.

## Configuration
- `BRANCH_STACK_EN` defined: return stack, `call_i`/`ret_i` semantics and both error flags are present.
- `BRANCH_STACK_EN` undefined:
  - No stack storage is generated.
  - `call_i` acts exactly as `branch_en_i` (conditional jump, no push).
  - `ret_i` is ignored; it neither holds nor increments.
  - `depth_o`, `stack_overflow_o` and `stack_underflow_o` are tied to 0.

## Structure
- `arch_defs_pkg`: `cond_e` enum (3-bit) and the `COND_*` constants. `ADDR_WIDTH` continues to come from the package default.
- Sub-module `return_stack`: a LIFO holding `STACK_DEPTH` entries of `ADDR_WIDTH` bits.
  - Inputs: push/pop. Outputs: top, full, empty, depth.
  - It is instantiated only under `BRANCH_STACK_EN`.
- Condition decode is a function inside `pc_branch_unit`.

## Test plan
- Reset with `RESET_VECTOR=8'h10`, then 3 cycles of `pc_inc_i` -> `pc_o` = 0x10, 0x11, 0x12, 0x13, with `branch_taken_o` never high.
- Z=1, branch cond=Z, target 0x05 -> `pc_o=0x05` next edge and `branch_taken_o` pulses once. Same with Z=0 and `pc_inc_i` high -> PC+1 and no pulse.
- Sweep all 8 conditions against all Z/C/N combinations -> taken exactly when the decode table says. NEVER is never taken, ALWAYS is always taken.
- PC at 0xFF with inc -> 0x00. `ADDR_WIDTH=12`: 0xFFF -> 0x000.
- Stack (`BRANCH_STACK_EN`, depth 4): calls from 0x20/0x30/0x40/0x50 to 0x80, then a 5th call -> PC holds, `stack_overflow_o=1`, depth 4. Four rets -> 0x50, 0x40, 0x30, 0x20. A 5th ret -> PC unchanged and `stack_underflow_o=1`.
- Simultaneous call+ret with depth 2, top 0x30 -> `pc_o=0x30`, depth 1. Reset pulse mid-run -> PC=RESET_VECTOR and depth 0 immediately, without waiting for a clock edge.
